// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 constants: register numbers, ExcCodes, exception-vector bit indices
// and Status/Cause field positions.
package cp0_exception_unit_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_CODE_INT  = 5'd0;
    localparam logic [4:0] EXC_CODE_ADEL = 5'd4;
    localparam logic [4:0] EXC_CODE_ADES = 5'd5;
    localparam logic [4:0] EXC_CODE_SYS  = 5'd8;
    localparam logic [4:0] EXC_CODE_BP   = 5'd9;
    localparam logic [4:0] EXC_CODE_RI   = 5'd10;
    localparam logic [4:0] EXC_CODE_OV   = 5'd12;

    localparam int EXC_ERET   = 0;
    localparam int EXC_ADES   = 1;
    localparam int EXC_ADEL_D = 2;
    localparam int EXC_ADEL_I = 3;
    localparam int EXC_OV     = 4;
    localparam int EXC_RI     = 5;
    localparam int EXC_BP     = 6;
    localparam int EXC_SYS    = 7;

    localparam int ST_IE      = 0;
    localparam int ST_EXL     = 1;
    localparam int ST_IM_LO   = 8;
    localparam int CA_EXC_LO  = 2;
    localparam int CA_IP_LO   = 8;
    localparam int CA_TI      = 30;
    localparam int CA_BD      = 31;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    typedef enum logic [1:0] {BV_NONE, BV_PC, BV_MEM} bv_sel_e;
    typedef enum logic {ST_RUN, ST_FLUSH} cp0_state_e;

endpackage

// File: rtl/cp0_exc_prioritizer.sv
// Combinational exception prioritiser: picks the highest-ranked cause and the
// source for BadVAddr. Interrupts outrank every except_in bit.
module cp0_exc_prioritizer
    import cp0_exception_unit_pkg::*;
(
    input  logic [8:0] except_in,
    input  logic       int_pend,
    output logic       take,
    output logic [4:0] exccode,
    output bv_sel_e    badvaddr_sel
);

    // Bit 8 is reserved and eret is handled by the caller.
    logic unused_bits;
    assign unused_bits = except_in[8] ^ except_in[EXC_ERET];

    always_comb begin
        take         = 1'b1;
        exccode      = EXC_CODE_INT;
        badvaddr_sel = BV_NONE;
        if (int_pend) begin
            exccode = EXC_CODE_INT;
        end else if (except_in[EXC_ADEL_I]) begin
            exccode      = EXC_CODE_ADEL;
            badvaddr_sel = BV_PC;
        end else if (except_in[EXC_RI]) begin
            exccode = EXC_CODE_RI;
        end else if (except_in[EXC_OV]) begin
            exccode = EXC_CODE_OV;
        end else if (except_in[EXC_SYS]) begin
            exccode = EXC_CODE_SYS;
        end else if (except_in[EXC_BP]) begin
            exccode = EXC_CODE_BP;
        end else if (except_in[EXC_ADEL_D]) begin
            exccode      = EXC_CODE_ADEL;
            badvaddr_sel = BV_MEM;
        end else if (except_in[EXC_ADES]) begin
            exccode      = EXC_CODE_ADES;
            badvaddr_sel = BV_MEM;
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 commit-point exception unit: Status/Cause/EPC/BadVAddr, one-cycle flush
// with redirect PC, mtc0/mfc0. Optional Count/Compare timer via CP0_TIMER_INT_EN.
module cp0_exception_unit
    import cp0_exception_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter logic [31:0] RESET_STATUS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [8:0]  except_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_addr_in,
    input  logic        delay_slot_in,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        exl
);

    cp0_state_e  state_q, state_d;
    logic [31:0] status_q, epc_q, badvaddr_q, new_pc_q;
    logic        bd_q, ti;
    logic [1:0]  ip_sw_q;
    logic [5:0]  ip_hw_q;
    logic [4:0]  exccode_q;
    logic [7:0]  cause_ip;
    logic [31:0] cause_rd;
    logic        int_pend, slot, pri_take, take, eret, wr;
    logic [4:0]  pri_code;
    bv_sel_e     pri_bv;

    assign cause_ip = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};
    assign int_pend = (|(cause_ip & status_q[ST_IM_LO +: 8])) & status_q[ST_IE] & ~status_q[ST_EXL];
    assign cause_rd = {bd_q, ti, 14'b0, cause_ip, 1'b0, exccode_q, 2'b0};

    // Commit is only honoured in RUN; the FLUSH cycle holds a squashed bubble.
    assign slot = commit_valid & (state_q == ST_RUN);

    cp0_exc_prioritizer u_pri (
        .except_in   (except_in),
        .int_pend    (int_pend),
        .take        (pri_take),
        .exccode     (pri_code),
        .badvaddr_sel(pri_bv)
    );

    assign take = slot & pri_take;
    assign eret = slot & except_in[EXC_ERET] & ~pri_take;
    assign wr   = cp0_we & ~take & ~eret;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (take || eret) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= RESET_STATUS & STATUS_WMASK;
            epc_q      <= '0;
            badvaddr_q <= '0;
            new_pc_q   <= '0;
            bd_q       <= 1'b0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            exccode_q  <= '0;
        end else begin
            ip_hw_q <= hw_int;
            if (take) begin
                exccode_q        <= pri_code;
                status_q[ST_EXL] <= 1'b1;
                new_pc_q         <= EXC_VECTOR;
                if (!status_q[ST_EXL]) begin
                    epc_q <= delay_slot_in ? pc_in - 32'd4 : pc_in;
                    bd_q  <= delay_slot_in;
                end
                case (pri_bv)
                    BV_PC:   badvaddr_q <= pc_in;
                    BV_MEM:  badvaddr_q <= mem_addr_in;
                    default: ;
                endcase
            end else if (eret) begin
                status_q[ST_EXL] <= 1'b0;
                new_pc_q         <= epc_q;
            end else if (wr) begin
                case (cp0_waddr)
                    REG_STATUS: status_q <= cp0_wdata & STATUS_WMASK;
                    REG_CAUSE:  ip_sw_q  <= cp0_wdata[CA_IP_LO +: 2];
                    REG_EPC:    epc_q    <= cp0_wdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_INT_EN
    logic [31:0] count_q, compare_q;
    logic        half_q, ti_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            half_q    <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            half_q <= ~half_q;
            if (wr && cp0_waddr == REG_COUNT) count_q <= cp0_wdata;
            else if (half_q)                  count_q <= count_q + 32'd1;
            // A Compare write acknowledges the timer and wins over a same-cycle match.
            if (wr && cp0_waddr == REG_COMPARE) begin
                compare_q <= cp0_wdata;
                ti_q      <= 1'b0;
            end else if (count_q == compare_q && compare_q != 32'd0) begin
                ti_q <= 1'b1;
            end
        end
    end
    assign ti = ti_q;
`else
    assign ti = 1'b0;
`endif

    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            REG_BADVADDR: cp0_rdata = badvaddr_q;
            REG_STATUS:   cp0_rdata = status_q;
            REG_CAUSE:    cp0_rdata = cause_rd;
            REG_EPC:      cp0_rdata = epc_q;
`ifdef CP0_TIMER_INT_EN
            REG_COUNT:    cp0_rdata = count_q;
            REG_COMPARE:  cp0_rdata = compare_q;
`endif
            default:      cp0_rdata = '0;
        endcase
    end

    assign flush  = (state_q == ST_FLUSH);
    assign new_pc = new_pc_q;
    assign exl    = status_q[ST_EXL];

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed-vector bench for cp0_exception_unit; timer checks run when
// CP0_TIMER_INT_EN is defined.
module tb_cp0_exception_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [8:0]  except_in;
    logic [31:0] pc_in, mem_addr_in;
    logic        delay_slot_in;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_waddr, cp0_raddr;
    logic [31:0] cp0_wdata, cp0_rdata, new_pc;
    logic        flush, exl;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    cp0_exception_unit dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .except_in(except_in),
        .pc_in(pc_in), .mem_addr_in(mem_addr_in), .delay_slot_in(delay_slot_in),
        .hw_int(hw_int), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .flush(flush), .new_pc(new_pc), .exl(exl)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        commit_valid = 0; except_in = '0; delay_slot_in = 0; cp0_we = 0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        cp0_raddr = a;
        #1;
        v = cp0_rdata;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1; cp0_waddr = a; cp0_wdata = d;
        step();
        cp0_we = 0;
    endtask

    task automatic commit(input logic [8:0] e, input logic [31:0] pc, input logic [31:0] ma, input logic ds);
        commit_valid = 1; except_in = e; pc_in = pc; mem_addr_in = ma; delay_slot_in = ds;
        step();
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1; idle(); hw_int = '0; pc_in = '0; mem_addr_in = '0;
        cp0_waddr = '0; cp0_wdata = '0; cp0_raddr = '0;
        step(); step();
        rst = 0;
        vecs++; if (flush !== 1'b0 || new_pc !== 32'h0 || exl !== 1'b0) begin
            errs++; $display("FAIL reset_out: flush=%b new_pc=%h exl=%b want 0/0/0", flush, new_pc, exl); end
        rd(5'd12, v); vecs++; if (v !== 32'h0) begin errs++; $display("FAIL reset_status: got %h want 0", v); end
        rd(5'd13, v); vecs++; if (v !== 32'h0) begin errs++; $display("FAIL reset_cause: got %h want 0", v); end
        rd(5'd14, v); vecs++; if (v !== 32'h0) begin errs++; $display("FAIL reset_epc: got %h want 0", v); end
        rd(5'd8, v);  vecs++; if (v !== 32'h0) begin errs++; $display("FAIL reset_badvaddr: got %h want 0", v); end
    endtask

    task automatic test_store_ades();
        logic [31:0] c, e, b;
        commit(9'h002, 32'h0040_0010, 32'h1000_0003, 0);
        vecs++; if (flush !== 1'b1 || new_pc !== 32'hBFC0_0380 || exl !== 1'b1) begin
            errs++; $display("FAIL ades_flush: flush=%b new_pc=%h exl=%b want 1/bfc00380/1", flush, new_pc, exl); end
        rd(5'd13, c); rd(5'd14, e); rd(5'd8, b);
        vecs++; if (c !== 32'h0000_0014) begin errs++; $display("FAIL ades_cause: got %h want 00000014", c); end
        vecs++; if (e !== 32'h0040_0010) begin errs++; $display("FAIL ades_epc: got %h want 00400010", e); end
        vecs++; if (b !== 32'h1000_0003) begin errs++; $display("FAIL ades_badvaddr: got %h want 10000003", b); end
        step();
        vecs++; if (flush !== 1'b0) begin errs++; $display("FAIL ades_flush_1cyc: got %b want 0", flush); end
        mtc0(5'd12, 32'h0);
    endtask

    task automatic test_delay_slot();
        logic [31:0] c, e, b;
        commit(9'h004, 32'h0040_0024, 32'h1000_0001, 1);
        rd(5'd13, c); rd(5'd14, e); rd(5'd8, b);
        vecs++; if (c !== 32'h8000_0010) begin errs++; $display("FAIL ds_cause: got %h want 80000010", c); end
        vecs++; if (e !== 32'h0040_0020) begin errs++; $display("FAIL ds_epc: got %h want 00400020", e); end
        vecs++; if (b !== 32'h1000_0001) begin errs++; $display("FAIL ds_badvaddr: got %h want 10000001", b); end
        step();
        mtc0(5'd12, 32'h0);
    endtask

    task automatic test_priority();
        logic [31:0] c, e, b;
        commit(9'h016, 32'h0040_0030, 32'h2000_0002, 0);
        rd(5'd13, c); rd(5'd14, e); rd(5'd8, b);
        vecs++; if (c !== 32'h0000_0030) begin errs++; $display("FAIL prio_cause: got %h want 00000030", c); end
        vecs++; if (e !== 32'h0040_0030) begin errs++; $display("FAIL prio_epc: got %h want 00400030", e); end
        vecs++; if (b !== 32'h1000_0001) begin errs++; $display("FAIL prio_badvaddr: got %h want 10000001", b); end
        step();
        // Nested: EXL still 1, syscall records code but keeps EPC.
        commit(9'h080, 32'h0040_0050, 32'h0, 1);
        rd(5'd13, c); rd(5'd14, e);
        vecs++; if (c !== 32'h0000_0020) begin errs++; $display("FAIL nest_cause: got %h want 00000020", c); end
        vecs++; if (e !== 32'h0040_0030) begin errs++; $display("FAIL nest_epc: got %h want 00400030", e); end
        step();
        // Fetch AdEL outranks syscall, BadVAddr from PC.
        commit(9'h088, 32'h0040_0060, 32'h3000_0000, 0);
        rd(5'd13, c); rd(5'd8, b);
        vecs++; if (c !== 32'h0000_0010) begin errs++; $display("FAIL adeli_cause: got %h want 00000010", c); end
        vecs++; if (b !== 32'h0040_0060) begin errs++; $display("FAIL adeli_badvaddr: got %h want 00400060", b); end
        step();
        // Breakpoint alone.
        mtc0(5'd12, 32'h0);
        commit(9'h040, 32'h0040_0064, 32'h0, 0);
        rd(5'd13, c);
        vecs++; if (c !== 32'h0000_0024) begin errs++; $display("FAIL bp_cause: got %h want 00000024", c); end
        step();
    endtask

    task automatic test_interrupt();
        logic [31:0] c, e;
        mtc0(5'd12, 32'h0000_0403);
        hw_int = 6'b000001;
        step();
        commit(9'h000, 32'h0040_0068, 32'h0, 0);
        vecs++; if (flush !== 1'b0) begin errs++; $display("FAIL int_masked_by_exl: flush=%b want 0", flush); end
        mtc0(5'd12, 32'h0000_0401);
        commit(9'h000, 32'h0040_0070, 32'h0, 0);
        hw_int = '0;
        rd(5'd13, c); rd(5'd14, e);
        vecs++; if (flush !== 1'b1 || new_pc !== 32'hBFC0_0380) begin
            errs++; $display("FAIL int_flush: flush=%b new_pc=%h want 1/bfc00380", flush, new_pc); end
        vecs++; if (c !== 32'h0000_0400) begin errs++; $display("FAIL int_cause: got %h want 00000400", c); end
        vecs++; if (e !== 32'h0040_0070) begin errs++; $display("FAIL int_epc: got %h want 00400070", e); end
        step();
    endtask

    task automatic test_eret();
        logic [31:0] e;
        mtc0(5'd14, 32'h0040_0100);
        commit_valid = 1; except_in = 9'h001;
        cp0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
        rd(5'd14, e);
        vecs++; if (e !== 32'h0040_0100) begin errs++; $display("FAIL eret_mfc0_old: got %h want 00400100", e); end
        step();
        cp0_we = 0;
        // FLUSH cycle: this commit must be squashed.
        commit_valid = 1; except_in = 9'h002; pc_in = 32'h0040_0200; mem_addr_in = 32'h4000_0001;
        vecs++; if (flush !== 1'b1 || new_pc !== 32'h0040_0100 || exl !== 1'b0) begin
            errs++; $display("FAIL eret_flush: flush=%b new_pc=%h exl=%b want 1/00400100/0", flush, new_pc, exl); end
        rd(5'd14, e);
        vecs++; if (e !== 32'h0040_0100) begin errs++; $display("FAIL eret_mtc0_dropped: got %h want 00400100", e); end
        step();
        idle();
        vecs++; if (flush !== 1'b0 || exl !== 1'b0) begin
            errs++; $display("FAIL flush_bubble: flush=%b exl=%b want 0/0", flush, exl); end
    endtask

    task automatic test_exc_over_eret();
        logic [31:0] c;
        commit(9'h011, 32'h0040_0300, 32'h0, 0);
        rd(5'd13, c);
        vecs++; if (flush !== 1'b1 || new_pc !== 32'hBFC0_0380 || exl !== 1'b1) begin
            errs++; $display("FAIL ov_over_eret: flush=%b new_pc=%h exl=%b want 1/bfc00380/1", flush, new_pc, exl); end
        vecs++; if (c !== 32'h0000_0030) begin errs++; $display("FAIL ov_over_eret_cause: got %h want 00000030", c); end
        step();
    endtask

    task automatic test_regmap();
        logic [31:0] v;
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, v);
        vecs++; if (v !== 32'h0000_0330) begin errs++; $display("FAIL cause_wmask: got %h want 00000330", v); end
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, v);
        vecs++; if (v !== 32'h0000_FF03) begin errs++; $display("FAIL status_wmask: got %h want 0000ff03", v); end
        mtc0(5'd8, 32'h1234_5678);
        rd(5'd8, v);
        vecs++; if (v !== 32'h0040_0060) begin errs++; $display("FAIL badvaddr_ro: got %h want 00400060", v); end
        mtc0(5'd5, 32'h1234_5678);
        rd(5'd5, v);
        vecs++; if (v !== 32'h0) begin errs++; $display("FAIL unmapped: got %h want 0", v); end
        mtc0(5'd12, 32'h0);
        mtc0(5'd13, 32'h0);
`ifndef CP0_TIMER_INT_EN
        mtc0(5'd11, 32'h5);
        rd(5'd11, v);
        vecs++; if (v !== 32'h0) begin errs++; $display("FAIL compare_absent: got %h want 0", v); end
`endif
    endtask

    task automatic test_reset_mid_flush();
        commit(9'h020, 32'h0040_0400, 32'h0, 0);
        vecs++; if (flush !== 1'b1) begin errs++; $display("FAIL ri_flush: got %b want 1", flush); end
        rst = 1;
        step();
        vecs++; if (flush !== 1'b0 || new_pc !== 32'h0 || exl !== 1'b0) begin
            errs++; $display("FAIL rst_mid_flush: flush=%b new_pc=%h exl=%b want 0/0/0", flush, new_pc, exl); end
        rst = 0;
        step();
    endtask

`ifdef CP0_TIMER_INT_EN
    task automatic test_timer();
        logic [31:0] c;
        int n;
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd0);
        n = 0;
        rd(5'd13, c);
        while (c[30] !== 1'b1 && n < 40) begin
            step(); n++; rd(5'd13, c);
        end
        vecs++; if (c[30] !== 1'b1 || n < 15) begin
            errs++; $display("FAIL timer_ti: cause=%h after %0d cycles want TI=1 near 20", c, n); end
        commit(9'h000, 32'h0040_0500, 32'h0, 0);
        rd(5'd13, c);
        vecs++; if (flush !== 1'b1 || c[6:2] !== 5'd0 || c[15] !== 1'b1) begin
            errs++; $display("FAIL timer_int: flush=%b cause=%h want flush 1 code 0 IP7", flush, c); end
        step();
        mtc0(5'd11, 32'd1000);
        rd(5'd13, c);
        vecs++; if (c[30] !== 1'b0) begin errs++; $display("FAIL timer_clear: cause=%h want TI=0", c); end
    endtask
`endif

    initial begin
        test_reset();
        test_store_ades();
        test_delay_slot();
        test_priority();
        test_interrupt();
        test_eret();
        test_exc_over_eret();
        test_regmap();
        test_reset_mid_flush();
`ifdef CP0_TIMER_INT_EN
        test_timer();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
